// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder controller: state encoding and default width.
package serial_adder_pkg;

    localparam int SA_WIDTH_DEFAULT = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } sa_state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell built from two half adders.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
    half_adder u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

    assign co = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder cell.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder swept over WIDTH bits, LSB first, with
// valid/ready handshakes on the operand and result sides.
//
//   state  | meaning
//   IDLE   | waiting for an operand pair (in_ready high)
//   RUN    | adding one bit per cycle, carry held in a flop
//   DONE   | result presented (out_valid high) until out_ready
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    sa_state_e        state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] res_shift;

    full_adder u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB so the result is LSB-aligned after WIDTH shifts.
    if (WIDTH == 1) begin : g_res_w1
        assign res_shift = fa_s;
    end else begin : g_res_wn
        assign res_shift = {fa_s, res_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                res_d   = res_shift;
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = res_shift;
                    cout_d  = fa_co;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // WIDTH=8 instance
    logic       rst8_n, iv8, ir8, ov8, or8, co8, busy8, ci8;
    logic [7:0] a8, b8, s8;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst8_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .cin(ci8), .out_valid(ov8), .out_ready(or8),
        .sum(s8), .cout(co8), .busy(busy8)
    );

    // WIDTH=1 instance
    logic       rst1_n, iv1, ir1, ov1, or1, co1, busy1, ci1;
    logic [0:0] a1, b1, s1;

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .cin(ci1), .out_valid(ov1), .out_ready(or1),
        .sum(s1), .cout(co1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one pair at a negedge, then count edges until out_valid.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec, input bit chk_lat);
        int lat;
        @(negedge clk);
        chk({tag, "_in_ready"}, ir8, 1'b1);
        iv8 = 1'b1; a8 = a; b8 = b; ci8 = c;
        @(negedge clk);
        iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; ci8 = 1'b0;
        chk({tag, "_busy"}, busy8, 1'b1);
        lat = 0;
        while (!ov8 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (chk_lat) chk({tag, "_latency"}, lat, 8);
        chk({tag, "_sum"}, s8, es);
        chk({tag, "_cout"}, co8, ec);
    endtask

    logic [7:0] st_a[4]  = '{8'hA5, 8'h80, 8'h37, 8'hC3};
    logic [7:0] st_b[4]  = '{8'h5A, 8'h81, 8'h19, 8'h7E};
    logic       st_c[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0] fa_tt[8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    initial begin
        rst8_n = 1'b0; iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; ci8 = 1'b0;
        rst1_n = 1'b0; iv1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0; ci1 = 1'b0;
        #12;
        chk("rst_in_ready", ir8, 1'b1);
        chk("rst_out_valid", ov8, 1'b0);
        chk("rst_busy", busy8, 1'b0);
        chk("rst_sum", s8, 8'h00);
        chk("rst_cout", co8, 1'b0);
        @(negedge clk);
        rst8_n = 1'b1; rst1_n = 1'b1;

        op8("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1);
        op8("add_ff_00_c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1);

        // Backpressure: result held, new operands ignored while in DONE.
        @(negedge clk);
        or8 = 1'b0;
        op8("bp", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b1);
        iv8 = 1'b1; a8 = 8'hAA; b8 = 8'h01; ci8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_sum", s8, 8'h47);
            chk("bp_cout", co8, 1'b0);
            chk("bp_out_valid", ov8, 1'b1);
            chk("bp_in_ready", ir8, 1'b0);
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", ir8, 1'b1);
        chk("bp_sum_kept", s8, 8'h47);

        // Reset at cnt=3 of F0+0F.
        iv8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F; ci8 = 1'b0;
        @(negedge clk);
        iv8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", busy8, 1'b1);
        rst8_n = 1'b0;
        #1;
        chk("mid_rst_sum", s8, 8'h00);
        chk("mid_rst_cout", co8, 1'b0);
        chk("mid_rst_out_valid", ov8, 1'b0);
        chk("mid_rst_busy", busy8, 1'b0);
        chk("mid_rst_in_ready", ir8, 1'b1);
        @(negedge clk);
        rst8_n = 1'b1;
        op8("post_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b1);

        // Streaming: in_valid held, results every WIDTH+2 cycles.
        begin
            int cyc, last, ri, ii;
            bit acc;
            logic [8:0] tot;
            cyc = 0; last = 0; ri = 0; ii = 0; acc = 1'b0;
            @(negedge clk);
            iv8 = 1'b1; a8 = st_a[0]; b8 = st_b[0]; ci8 = st_c[0];
            while (ri < 4 && cyc < 200) begin
                if (ov8) begin
                    tot = {1'b0, st_a[ri]} + {1'b0, st_b[ri]} + {8'h00, st_c[ri]};
                    chk("stream_sum", s8, tot[7:0]);
                    chk("stream_cout", co8, tot[8]);
                    if (ri > 0) chk("stream_spacing", cyc - last, 10);
                    last = cyc;
                    ri++;
                end
                if (acc) begin
                    ii++;
                    if (ii < 4) begin
                        a8 = st_a[ii]; b8 = st_b[ii]; ci8 = st_c[ii];
                    end else begin
                        iv8 = 1'b0;
                    end
                end
                acc = ir8 && iv8;
                @(negedge clk);
                cyc++;
            end
            chk("stream_results", ri, 4);
            iv8 = 1'b0;
        end

        // WIDTH=1 truth table.
        for (int i = 0; i < 8; i++) begin
            int lat;
            logic [2:0] v;
            v = i[2:0];
            @(negedge clk);
            iv1 = 1'b1; a1 = v[2]; b1 = v[1]; ci1 = v[0];
            @(negedge clk);
            iv1 = 1'b0;
            lat = 0;
            while (!ov1 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            chk("w1_latency", lat, 1);
            chk("w1_result", {co1, s1}, fa_tt[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller. It sequences one full_adder instance over a WIDTH-bit operand pair, one bit per clock, LSB first, and carries the ripple carry in a flop between cycles. Operands arrive on a valid/ready input handshake. The result leaves on a valid/ready output handshake. It is the area-minimal alternative to the ripple-carry adder in the benchmarking set.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..64.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand pair present.
in_ready  output  1  controller can accept operands.
a  input  WIDTH  operand A, sampled on input handshake.
b  input  WIDTH  operand B, sampled on input handshake.
cin  input  1  carry-in, sampled on input handshake.
out_valid  output  1  sum/cout valid.
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  registered sum.
cout  output  1  registered carry-out.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; operand, result and carry registers = 0; bit counter = 0; sum = 0; cout = 0; out_valid = 0; busy = 0.
- Clock and reset ports are named clk and rst_n. There is one clock domain. Reset is asynchronous assert and active-low. Deassertion is synchronised externally.
- FSM states: IDLE, RUN, DONE.
- in_ready = (state == IDLE). It is combinational from the state register only, so it reads 1 while in reset.
- out_valid = (state == DONE). It is registered via state.
- IDLE:
  - On in_valid && in_ready, latch a_sh <= a, b_sh <= b, carry <= cin, cnt <= 0, and go to RUN.
  - If in_valid is low, stay in IDLE.
- RUN (one bit per cycle):
  - full_adder inputs are a_sh[0], b_sh[0] and carry.
  - Each edge: shift a_sh and b_sh right by 1. Shift the adder sum into the result MSB (res <= {s, res[WIDTH-1:1]}). carry <= adder cout. cnt <= cnt + 1.
  - On the edge where cnt == WIDTH-1, go to DONE.
  - At the same edge, the final carry is written into the cout register and res is copied to sum.
- DONE:
  - sum and cout are held stable. in_ready = 0, and in_valid is ignored.
  - On out_ready high, go to IDLE. sum and cout keep their values until the next DONE.
- Latency: out_valid rises exactly WIDTH cycles after the accepting edge.
- Throughput with out_ready tied high and in_valid held: one result every WIDTH+2 cycles (accept, WIDTH bit cycles, output handshake).
- Width rules:
  - cnt is $clog2(WIDTH) bits, minimum 1.
  - sum is the low WIDTH bits of a+b+cin. cout is bit WIDTH of that total.
- Boundary conditions:
  - WIDTH=1: RUN lasts one cycle.
  - in_valid asserted during RUN or DONE: no effect, and the operands are not sampled. The source must hold them until in_ready.
  - out_ready asserted before DONE: ignored.
  - rst_n asserted mid-RUN or in DONE: immediate return to the reset values. The partial result is discarded and no out_valid is produced.
  - No simultaneous in/out handshake is possible, because IDLE and DONE are exclusive.

Decomposition:
- Shared package (serial_adder_pkg) holds:
  - the state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the default width constant.
- Sub-module: exactly one full_adder instance (existing cell, built from two half_adder instances). No other hierarchy; the FSM, shifters and counter stay in serial_adder_ctrl.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h3C, cin=0, out_ready=1 -> out_valid high 8 cycles after accept; sum=8'h96, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1.
- Backpressure: a=8'h12, b=8'h34, cin=1, out_ready low for 5 cycles after DONE -> sum=8'h47 and cout=0 held stable; out_valid=1 and in_ready=0 throughout. A new in_valid with a=8'hAA during that window is not sampled.
- Reset mid-operation: assert rst_n=0 asynchronously at cnt=3 of a=8'hF0+b=8'h0F -> sum=0, cout=0, out_valid=0 and busy=0 immediately. After release, in_ready=1 and the next operation (8'h01+8'h01) yields 8'h02.
- Streaming: in_valid held with 4 operand pairs, out_ready=1 -> results spaced exactly 10 cycles apart; all sums match a+b+cin against a reference model.
- WIDTH=1 build: all 8 (a,b,cin) combinations -> {cout,sum} equals the full-adder truth table; out_valid 1 cycle after accept.
